// File: rtl/addsub_pipe.sv
// Segmented, pipelined add/sub/compare unit with a valid/ready handshake.
// The carry chain is split into SEG-bit slices, and one slice is resolved per stage.
module addsub_pipe #(
  parameter int WIDTH = 64,
  parameter int SEG   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;
  // Intermediate stage registers; the final stage writes straight into the output registers.
  localparam int DATA   = (STAGES > 1) ? STAGES - 1 : 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SLT = 2'b10;
  localparam logic [1:0] OP_SLTU = 2'b11;

  if (WIDTH % SEG != 0) begin : g_bad_seg
    $error("addsub_pipe: WIDTH must be a multiple of SEG");
  end

  logic [STAGES-1:0] vld_q, vld_d;
  logic [WIDTH-1:0]  a_q   [DATA];
  logic [WIDTH-1:0]  a_d   [DATA];
  logic [WIDTH-1:0]  be_q  [DATA];
  logic [WIDTH-1:0]  be_d  [DATA];
  logic [WIDTH-1:0]  sum_q [DATA];
  logic [WIDTH-1:0]  sum_d [DATA];
  logic [1:0]        op_q  [DATA];
  logic [1:0]        op_d  [DATA];
  logic              cy_q  [DATA];
  logic              cy_d  [DATA];
  logic [WIDTH-1:0]  result_q, result_d;
  logic              carry_q, carry_d;
  logic              overflow_q, overflow_d;
  logic              zero_q, zero_d;
  logic              advance;

  assign out_valid = vld_q[LAST];
  assign advance   = !vld_q[LAST] || out_ready;
  assign in_ready  = advance;
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

  // Slice-by-slice add; stage k takes its operands and carry from stage k-1 (or the ports).
  always_comb begin
    logic [WIDTH-1:0] sa, sb, ss;
    logic [1:0]       so;
    logic             sc;
    logic [SEG:0]     seg;
    logic             lt;
    int               idx;
    int               kd;

    sa = a; sb = b; ss = '0; so = op; sc = 1'b0; seg = '0; lt = 1'b0;
    idx = 0; kd = 0;
    for (int i = 0; i < DATA; i++) begin
      a_d[i]   = a_q[i];
      be_d[i]  = be_q[i];
      sum_d[i] = sum_q[i];
      op_d[i]  = op_q[i];
      cy_d[i]  = cy_q[i];
    end
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;

    vld_d[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      vld_d[k] = vld_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      idx = (k == 0) ? 0 : k - 1;
      kd  = (k < LAST) ? k : 0;
      if (k != 0) begin
        sa = a_q[idx];
        sb = be_q[idx];
        ss = sum_q[idx];
        so = op_q[idx];
        sc = cy_q[idx];
      end else begin
        sa = a;
        sb = (op == OP_ADD) ? b : ~b;
        ss = '0;
        so = op;
        sc = (op != OP_ADD);
      end
      seg = {1'b0, sa[k*SEG +: SEG]} + {1'b0, sb[k*SEG +: SEG]} + {{SEG{1'b0}}, sc};
      ss[k*SEG +: SEG] = seg[SEG-1:0];

      if (k < LAST) begin
        a_d[kd]   = sa;
        be_d[kd]  = sb;
        sum_d[kd] = ss;
        op_d[kd]  = so;
        cy_d[kd]  = seg[SEG];
      end else begin
        carry_d    = (so == OP_ADD) ? seg[SEG] : ~seg[SEG];
        overflow_d = (sa[WIDTH-1] == sb[WIDTH-1]) && (ss[WIDTH-1] != sa[WIDTH-1]);
        lt         = (so == OP_SLT) ? (ss[WIDTH-1] ^ overflow_d) : ~seg[SEG];
        case (so)
          OP_SLT, OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, lt};
          default:         result_d = ss;
        endcase
        zero_d = (result_d == {WIDTH{1'b0}});
      end
    end
  end

  // Whole pipeline advances together or freezes together; bubbles travel like beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q      <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      for (int i = 0; i < DATA; i++) begin
        a_q[i]   <= '0;
        be_q[i]  <= '0;
        sum_q[i] <= '0;
        op_q[i]  <= 2'b00;
        cy_q[i]  <= 1'b0;
      end
    end else if (advance) begin
      vld_q      <= vld_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      for (int i = 0; i < DATA; i++) begin
        a_q[i]   <= a_d[i];
        be_q[i]  <= be_d[i];
        sum_q[i] <= sum_d[i];
        op_q[i]  <= op_d[i];
        cy_q[i]  <= cy_d[i];
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe (WIDTH=64, SEG=16): the driver queues expected results,
// and the monitor pops and compares them on each output handshake.
module tb_addsub_pipe;

  localparam int WIDTH  = 64;
  localparam int SEG    = 16;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, out_valid, out_ready;
  logic             carry, overflow, zero;
  logic [1:0]       op;
  logic [WIDTH-1:0] a, b, result;

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry(carry), .overflow(overflow), .zero(zero)
  );

  typedef struct {
    logic [63:0] res;
    logic [2:0]  flg;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
    end
  endtask

  // Monitor: checks hold-while-stalled and pops one expectation per output handshake.
  logic        stall_prev = 1'b0;
  logic [63:0] hold_res;
  logic [2:0]  hold_flg;
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_result", result, hold_res);
        chk("stall_flags", 64'({carry, overflow, zero}), 64'(hold_flg));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=0x%h expected=no_beat", result);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("flags_c_v_z", 64'({carry, overflow, zero}), 64'(e.flg));
          if (e.lat) chk("latency", 64'(cyc - e.acc), 64'(STAGES));
        end
      end
      stall_prev = out_valid && !out_ready;
      hold_res   = result;
      hold_flg   = {carry, overflow, zero};
    end
  end

  // Call at a falling edge; returns at a later falling edge with in_valid low.
  task automatic do_beat(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                         input logic [63:0] r, input logic [2:0] f, input bit lat);
    int n;
    op = o; a = x; b = y; in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    else sb.push_back('{r, f, cyc, lat});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  logic [1:0]  s_op [8] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd3, 2'd2, 2'd0, 2'd1};
  logic [63:0] s_a  [8] = '{64'd1, 64'd10, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'd3, 64'd5,
                            64'h0000_FFFF_0000_FFFF, 64'h100};
  logic [63:0] s_b  [8] = '{64'd2, 64'd3, 64'd1, 64'd0, 64'd5, 64'd3,
                            64'h0000_0001_0000_0001, 64'd1};
  logic [63:0] s_r  [8] = '{64'd3, 64'd7, 64'h8000_0000_0000_0000, 64'd0, 64'd1, 64'd0,
                            64'h0001_0000_0001_0000, 64'hFF};
  logic [2:0]  s_f  [8] = '{3'b000, 3'b000, 3'b010, 3'b001, 3'b100, 3'b001, 3'b000, 3'b000};

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 2'b00; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_flags", 64'({carry, overflow, zero}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    do_beat(2'b01, 64'hA, 64'h5, 64'h5, 3'b000, 1'b1);
    do_beat(2'b01, 64'h5, 64'hA, 64'hFFFF_FFFF_FFFF_FFFB, 3'b100, 1'b1);
    do_beat(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 3'b101, 1'b1);
    do_beat(2'b01, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 3'b010, 1'b1);
    do_beat(2'b10, 64'h8000_0000_0000_0000, 64'h1, 64'h1, 3'b010, 1'b1);
    do_beat(2'b11, 64'h8000_0000_0000_0000, 64'h1, 64'h0, 3'b011, 1'b1);
    do_beat(2'b01, 64'h1234_5678_90AB_CDEF, 64'h1234_5678_90AB_CDEF, 64'h0, 3'b001, 1'b1);
    drain();

    fork
      begin
        for (int i = 0; i < 8; i++) do_beat(s_op[i], s_a[i], s_b[i], s_r[i], s_f[i], 1'b0);
      end
      begin
        repeat (6) @(negedge clk);
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
          #1;
          chk("in_ready_stall", 64'(in_ready), 64'd0);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    for (int i = 0; i < 3; i++) do_beat(2'b00, 64'd1, 64'd1, 64'd2, 3'b000, 1'b1);
    rst = 1'b1; in_valid = 1'b1; op = 2'b00; a = 64'd5; b = 64'd5;
    sb.delete();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", result, 64'd0);
    repeat (6) @(negedge clk);
    do_beat(2'b00, 64'h1111, 64'h2222, 64'h3333, 3'b000, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
